csa_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor; successor to the fixed 64-bit carry-select adder with CLA blocks.
- Operand width, CLA block width and pipeline depth are configurable.
- Adds add/subtract mode and a valid/ready handshake with backpressure.
- Sits in the datapath library as the standard registered wide adder for accumulator and address-generation paths.

---
 rtl/csa_pipe_adder_pkg.sv | 21 ++
 rtl/csa_pipe_adder_if.sv | 36 +++
 rtl/csa_pipe_adder_block.sv | 35 +++
 rtl/csa_pipe_adder.sv | 113 +++++++++++
 tb/tb_csa_pipe_adder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/csa_pipe_adder_pkg.sv
// rtl/csa_pipe_adder_pkg.sv - shared constants, slice helper and stage record for csa_pipe_adder
package csa_pkg;

  localparam int CSA_WIDTH = 64;
  localparam int CSA_BLK   = 8;
  localparam int CSA_NSTG  = 4;

  function automatic int csa_slice(input int width, input int nstg);
    return width / nstg;
  endfunction

  // Stage record at the default width; a and b carry effective (post-invert) operands.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [CSA_WIDTH-1:0] s;
    logic [CSA_WIDTH-1:0] a;
    logic [CSA_WIDTH-1:0] b;
  } csa_stage_t;

endpackage

// File: rtl/csa_pipe_adder_if.sv
// rtl/csa_pipe_adder_if.sv - operand/result handshake bundle; ovf present when CSA_PIPE_OVF_EN is defined
interface csa_pipe_adder_if
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CSA_PIPE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef CSA_PIPE_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef CSA_PIPE_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/csa_pipe_adder_block.sv
// rtl/csa_pipe_adder_block.sv - combinational BLK-bit carry-select block built from two CLA evaluations
module csa_block
  import csa_pkg::*;
#(
  parameter int BLK = CSA_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout
);
  logic [BLK-1:0] g;
  logic [BLK-1:0] p;
  logic [BLK:0]   c0;
  logic [BLK:0]   c1;

  assign g = a & b;
  assign p = a ^ b;

  // Both carry-in hypotheses are resolved up front; the incoming carry only drives the select.
  always_comb begin
    c0    = '0;
    c1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < BLK; i++) begin
      c0[i+1] = g[i] | (p[i] & c0[i]);
      c1[i+1] = g[i] | (p[i] & c1[i]);
    end
  end

  assign s    = cin ? (p ^ c1[BLK-1:0]) : (p ^ c0[BLK-1:0]);
  assign cout = cin ? c1[BLK] : c0[BLK];

endmodule

// File: rtl/csa_pipe_adder.sv
// rtl/csa_pipe_adder.sv - skewed-pipeline carry-select add/sub with backpressure; CSA_PIPE_OVF_EN adds ovf
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int BLK   = CSA_BLK,
  parameter int NSTG  = CSA_NSTG
) (
  input  logic             clk,
  input  logic             rst,
  csa_pipe_adder_if.slave  bus
);
  localparam int SLICE = csa_slice(WIDTH, NSTG);
  localparam int NBS   = SLICE / BLK;
  localparam int NB    = WIDTH / BLK;
  localparam logic [WIDTH-1:0] ONE = 1;

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t           stg    [NSTG];
  logic [WIDTH-1:0] a_src  [NSTG];
  logic [WIDTH-1:0] b_src  [NSTG];
  logic [WIDTH-1:0] s_prev [NSTG];
  logic [WIDTH-1:0] s_next [NSTG];
  logic             c_src  [NSTG];
  logic             c_out  [NSTG];
  logic             v_src  [NSTG];
  logic [WIDTH-1:0] blk_s;
  logic             en;
  logic             accept;

  assign en           = bus.out_ready | ~bus.out_valid;
  assign accept       = bus.in_valid & en;
  assign bus.in_ready = en;

  // Block j belongs to stage j/NBS; the block carry ripples only inside its own slice.
  for (genvar j = 0; j < NB; j++) begin : gen_blk
    localparam int K = j / NBS;
    logic           ci;
    logic           co;
    logic [BLK-1:0] s;
    if (j % NBS == 0) begin : g_first
      assign ci = c_src[K];
    end else begin : g_next
      assign ci = gen_blk[j-1].co;
    end
    csa_block #(.BLK(BLK)) u_blk (
      .a    (a_src[K][j*BLK +: BLK]),
      .b    (b_src[K][j*BLK +: BLK]),
      .cin  (ci),
      .s    (s),
      .cout (co)
    );
    assign blk_s[j*BLK +: BLK] = s;
  end

  for (genvar k = 0; k < NSTG; k++) begin : gen_stg
    localparam logic [WIDTH-1:0] MASK = ((ONE << SLICE) - ONE) << (k * SLICE);
    if (k == 0) begin : g_head
      assign a_src[k]  = bus.a;
      assign b_src[k]  = bus.sub ? ~bus.b : bus.b;
      assign c_src[k]  = bus.sub ^ bus.cin;
      assign s_prev[k] = '0;
      assign v_src[k]  = accept;
    end else begin : g_body
      assign a_src[k]  = stg[k-1].a;
      assign b_src[k]  = stg[k-1].b;
      assign c_src[k]  = stg[k-1].carry;
      assign s_prev[k] = stg[k-1].s;
      assign v_src[k]  = stg[k-1].valid;
    end
    assign c_out[k]  = gen_blk[(k+1)*NBS-1].co;
    assign s_next[k] = (s_prev[k] & ~MASK) | (blk_s & MASK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) stg[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < NSTG; k++) begin
        stg[k].valid <= v_src[k];
        stg[k].carry <= c_out[k];
        stg[k].s     <= s_next[k];
        stg[k].a     <= a_src[k];
        stg[k].b     <= b_src[k];
      end
    end
  end

  assign bus.out_valid = stg[NSTG-1].valid;
  assign bus.sum       = stg[NSTG-1].s;
  assign bus.cout      = stg[NSTG-1].carry;

`ifdef CSA_PIPE_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit: c = a ^ b ^ s.
  logic ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= a_src[NSTG-1][WIDTH-1] ^ b_src[NSTG-1][WIDTH-1] ^ blk_s[WIDTH-1] ^ c_out[NSTG-1];
    end
  end
  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb/tb_csa_pipe_adder.sv - scoreboard bench for csa_pipe_adder (64/8/4 and 32/4/2 instances)
module tb_csa_pipe_adder;
  import csa_pkg::*;

  localparam int W  = 64;
  localparam int W2 = 32;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;
  res_t exp_q[$];
  res_t obs_q[$];
  int   obs_cyc[$];
  res_t sb_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csa_pipe_adder_if #(.WIDTH(W))  bus  ();
  csa_pipe_adder_if #(.WIDTH(W2)) bus2 ();

  csa_pipe_adder #(.WIDTH(W), .BLK(8), .NSTG(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  csa_pipe_adder #(.WIDTH(W2), .BLK(4), .NSTG(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    logic [W:0] t;
    t = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, (sub ? ~cin : cin)};
    return {t[W-1:0], t[W]};
  endfunction

  // Scoreboard: expectations pushed at accept, compared when the result handshake happens.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        obs_q.push_back({bus.sum, bus.cout});
        obs_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_extra: got sum=%h cout=%b, expected no result", bus.sum, bus.cout);
        end else begin
          sb_e = exp_q.pop_front();
          if ({bus.sum, bus.cout} !== sb_e) begin
            errors++;
            $display("FAIL scoreboard: got sum=%h cout=%b, expected sum=%h cout=%b", bus.sum, bus.cout, sb_e.sum, sb_e.cout);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin, input logic tsub);
    bus.a = ta; bus.b = tb_v; bus.cin = tcin; bus.sub = tsub; bus.in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    checks++; if (bus.sum !== '0) begin errors++; $display("FAIL reset_sum: got %h, expected 0", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b, expected 0", bus.cout); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
    checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_w32: got %b, expected 0", bus2.out_valid); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int c0;
    obs_q.delete(); obs_cyc.delete();
    c0 = cyc;
    send(64'd2, 64'd5, 1'b0, 1'b0);
    idle(8);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL basic_count: got %0d results, expected 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_q[0] !== {64'd7, 1'b0}) begin errors++; $display("FAIL basic_value: got sum=%h cout=%b, expected sum=7 cout=0", obs_q[0].sum, obs_q[0].cout); end
      checks++; if (obs_cyc[0] - c0 != 4) begin errors++; $display("FAIL basic_latency: got %0d, expected 4", obs_cyc[0] - c0); end
    end
  endtask

  task automatic test_back_to_back;
    int c0;
    obs_q.delete(); obs_cyc.delete();
    c0 = cyc;
    send(64'd12, 64'd12, 1'b1, 1'b0);
    send(64'd12, 64'd12, 1'b0, 1'b0);
    send(64'd75, 64'd75, 1'b1, 1'b0);
    idle(8);
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d results, expected 3", obs_q.size()); end
    if (obs_q.size() == 3) begin
      checks++; if (obs_q[0].sum !== 64'd25) begin errors++; $display("FAIL b2b_sum0: got %0d, expected 25", obs_q[0].sum); end
      checks++; if (obs_q[1].sum !== 64'd24) begin errors++; $display("FAIL b2b_sum1: got %0d, expected 24", obs_q[1].sum); end
      checks++; if (obs_q[2].sum !== 64'd151) begin errors++; $display("FAIL b2b_sum2: got %0d, expected 151", obs_q[2].sum); end
      checks++; if (obs_cyc[0] - c0 != 4) begin errors++; $display("FAIL b2b_latency: got %0d, expected 4", obs_cyc[0] - c0); end
      checks++; if (obs_cyc[2] - obs_cyc[0] != 2) begin errors++; $display("FAIL b2b_spacing: got %0d, expected 2", obs_cyc[2] - obs_cyc[0]); end
    end
  endtask

  task automatic test_wrap_sub;
    obs_q.delete(); obs_cyc.delete();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    send(64'd5, 64'd7, 1'b0, 1'b1);
    send(64'd9213123, 64'd2223000, 1'b1, 1'b1);
    idle(8);
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL wrap_count: got %0d results, expected 3", obs_q.size()); end
    if (obs_q.size() == 3) begin
      checks++; if (obs_q[0] !== {64'd0, 1'b1}) begin errors++; $display("FAIL wrap_add: got sum=%h cout=%b, expected sum=0 cout=1", obs_q[0].sum, obs_q[0].cout); end
      checks++; if (obs_q[1] !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0}) begin errors++; $display("FAIL sub_borrow: got sum=%h cout=%b, expected sum=fffffffffffffffe cout=0", obs_q[1].sum, obs_q[1].cout); end
      checks++; if (obs_q[2] !== {64'd6990122, 1'b1}) begin errors++; $display("FAIL sub_cin: got sum=%0d cout=%b, expected sum=6990122 cout=1", obs_q[2].sum, obs_q[2].cout); end
    end
  endtask

  task automatic test_backpressure;
    int           idx;
    logic         acc;
    logic [W-1:0] held;
    logic [W-1:0] base;
    obs_q.delete(); obs_cyc.delete();
    base = 64'd2223000 + 64'd2021312300;
    idx = 0;
    bus.out_ready = 1'b0;
    bus.a = 64'd2223000; bus.cin = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.b = 64'd2021312300 + 64'(idx);
      @(negedge clk); acc = bus.in_valid & bus.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    checks++; if (idx != 4) begin errors++; $display("FAIL stall_accepts: got %0d, expected 4", idx); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b, expected 0", bus.in_ready); end
    checks++; if (bus.sum !== base) begin errors++; $display("FAIL stall_head: got %0d, expected %0d", bus.sum, base); end
    held = bus.sum;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (bus.sum !== held || bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold: got sum=%0d valid=%b, expected sum=%0d valid=1", bus.sum, bus.out_valid, held); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && idx < 5; c++) begin
      bus.b = 64'd2021312300 + 64'(idx);
      @(negedge clk); acc = bus.in_valid & bus.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    checks++; if (idx != 5) begin errors++; $display("FAIL release_accept: got %0d accepted, expected 5", idx); end
    idle(10);
    checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL release_count: got %0d results, expected 5", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 5; i++) begin
      checks++; if (obs_q[i].sum !== base + 64'(i)) begin errors++; $display("FAIL release_order%0d: got %0d, expected %0d", i, obs_q[i].sum, base + 64'(i)); end
    end
  endtask

  task automatic test_reset_flush;
    obs_q.delete(); obs_cyc.delete();
    send(64'd1, 64'd1, 1'b0, 1'b0);
    send(64'd2, 64'd2, 1'b0, 1'b0);
    send(64'd3, 64'd3, 1'b0, 1'b0);
    idle(1);
    checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 64'd2) begin errors++; $display("FAIL flush_pre: got valid=%b sum=%0d, expected valid=1 sum=2", bus.out_valid, bus.sum); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b, expected 0", bus.out_valid); end
    checks++; if (bus.sum !== '0) begin errors++; $display("FAIL flush_sum: got %h, expected 0", bus.sum); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    obs_q.delete(); obs_cyc.delete();
    send(64'd100, 64'd23, 1'b0, 1'b0);
    idle(10);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL flush_post_count: got %0d results, expected 1", obs_q.size()); end
    if (obs_q.size() == 1) begin
      checks++; if (obs_q[0].sum !== 64'd123) begin errors++; $display("FAIL flush_post_sum: got %0d, expected 123", obs_q[0].sum); end
    end
  endtask

  task automatic test_small_config;
    logic [W2-1:0] ta [3] = '{32'd2, 32'd5, 32'hFFFF_FFFF};
    logic [W2-1:0] tv [3] = '{32'd5, 32'd7, 32'd1};
    logic          ts [3] = '{1'b0, 1'b1, 1'b0};
    logic [W2-1:0] es [3] = '{32'd7, 32'hFFFF_FFFE, 32'd0};
    logic          ec [3] = '{1'b0, 1'b0, 1'b1};
    int            c0;
    int            lat;
    for (int t = 0; t < 3; t++) begin
      bus2.a = ta[t]; bus2.b = tv[t]; bus2.cin = 1'b0; bus2.sub = ts[t]; bus2.in_valid = 1'b1;
      c0 = cyc;
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      lat = -1;
      for (int i = 0; i < 10 && lat < 0; i++) begin
        if (bus2.out_valid === 1'b1) lat = cyc - c0;
        else begin @(posedge clk); #1; end
      end
      checks++; if (lat != 2) begin errors++; $display("FAIL w32_latency%0d: got %0d, expected 2", t, lat); end
      checks++; if (bus2.sum !== es[t] || bus2.cout !== ec[t]) begin errors++; $display("FAIL w32_value%0d: got sum=%h cout=%b, expected sum=%h cout=%b", t, bus2.sum, bus2.cout, es[t], ec[t]); end
      @(posedge clk); #1;
    end
  endtask

`ifdef CSA_PIPE_OVF_EN
  task automatic test_ovf;
    logic found;
    found = 1'b0;
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid === 1'b1 && !found) begin
        found = 1'b1;
        checks++; if (bus.sum !== 64'h8000_0000_0000_0000 || bus.cout !== 1'b0) begin errors++; $display("FAIL ovf_sum: got sum=%h cout=%b, expected sum=8000000000000000 cout=0", bus.sum, bus.cout); end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, expected 1", bus.ovf); end
      end
      @(posedge clk); #1;
    end
    checks++; if (!found) begin errors++; $display("FAIL ovf_timeout: got no result, expected one"); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sub = 1'b0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_wrap_sub;
    test_backpressure;
    test_reset_flush;
    test_small_config;
`ifdef CSA_PIPE_OVF_EN
    test_ovf;
`endif
    idle(6);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
